acc_requant: RTL and testbench
==============================

// Module: acc_requant
// PURPOSE
//  Requantizes mac accumulator results (intr 24b int / fpr 31b {e[4:0],m[25:0]}) back into the 16b
//  activation "value" format consumed by the mac, for the next layer. Rounds, shifts, applies ReLU,
//  saturates, packs two int8 results per word. 2-stage pipeline, valid/ready both sides.
// PARAMETERS
//  SAT_W    16  width of saturation event counter
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mode       in   2   per beat: 00 fp, 01 int_s, 10 int_m, 11 int_l
//  in_valid   in   1   input beat valid
//  in_ready   out  1   input beat accepted when in_valid & in_ready
//  in_intr    in   24  signed int accumulator (int modes)
//  in_fpr     in   31  fp accumulator {e[4:0] unsigned, m[25:0] signed, normalized m[25]!=m[24]} (fp)
//  in_shift   in   5   per-beat right shift for int modes (0..23); ignored in fp
//  in_last    in   1   last beat of tensor row; forces flush of partial int word
//  out_valid  out  1   out_value valid
//  out_ready  in   1   downstream accepts when out_valid & out_ready
//  out_value  out  16  int: {hi8,lo8}; fp: {e[3:0], man[11:0]} (implicit leading 1)
//  out_last   out  1   word contains the in_last beat
//  sat_clr    in   1   synchronous clear of sat_cnt
//  sat_cnt    out  SAT_W  saturating count of clamped results
// BEHAVIOUR
//  Reset: out_valid=0, out_value=0, out_last=0, sat_cnt=0, packer EMPTY, S1 empty; in_ready=1 after reset.
//  Pipeline: S1 registers accepted beat + rounding add; S2 (output reg) shift/clamp/pack.
//  - in_ready = !s1_valid | s1_adv; s1_adv = S2 can take it (out reg empty, or out_ready, or beat only
//    fills packer half). Full throughput 1 beat/cycle; no beat lost or duplicated under backpressure.
//  - Latency: beat accepted cycle t -> word on out at t+2 (fp, or int completing a pair / in_last).
//  - out_value/out_last stable while out_valid & !out_ready.
//  Int (modes 01/10/11 identical): r = (in_intr + (in_shift? 1<<(in_shift-1) : 0)) >>> in_shift,
//    26b signed intermediate (no overflow); r<0 -> 0 (ReLU, not a saturation); r>255 -> 255, sat_cnt++.
//  FP: m<0 -> 0x0000; m==0 -> 0x0000; else man = m[23:12] + m[11] (round half up);
//    man carry-out -> man=0, e=e+1; e>15 (before or after carry) -> 0xFFFF, sat_cnt++;
//    out = {e[3:0], man}. One fp result per word.
//  Packer FSM (int only): EMPTY --int beat, !last--> HALF (byte held as lo);
//    EMPTY --int beat, last--> emit {8'h0, b}, out_last=1, stay EMPTY;
//    HALF --int beat--> emit {b, lo}, out_last=in_last, EMPTY;
//    HALF & S1 holds fp beat -> emit {8'h0, lo} (out_last=0) first, fp beat held 1 extra cycle.
//    fp beat in EMPTY: emit directly.
//  sat_cnt: +1 per clamped result, holds at all-ones; sat_clr wins over same-cycle increment.
//  Reset mid-op: pending half byte, S1 and output word discarded immediately (async).
// TESTING
//  1 int_s shift=4: intr 0x000128, then 0x001000 -> out 0xFF13 at t+2 of 2nd beat, sat_cnt=1.
//  2 fp: fpr {7,26'h1000800} -> 0x7001; {7,26'h1FFF800} -> 0x8000; {15,26'h1FFF800} -> 0xFFFF, sat_cnt+1;
//    {7,26'h2000000} (negative) -> 0x0000.
//  3 int stream of 8 beats, out_ready low 5 cycles mid-stream -> in_ready drops, 4 words exact order, none lost.
//  4 3 int beats (10,20,30 shift 0), last on 3rd -> 0x140A then 0x001E with out_last=1.
//  5 int beat 0x05 then fp {3,26'h1000000} -> 0x0005 (out_last=0) then 0x3000; in_ready low 1 cycle.
//  6 rst pulse with packer HALF and out_valid=1 -> out_valid=0, sat_cnt=0; next pair packs fresh.

Source files
------------

// File: rtl/acc_requant.sv
// Requantizes mac accumulator results (24b int or 31b fp) into the 16b activation format.
// Two-stage pipeline: S1 holds the accepted beat with its rounding add, S2 shifts/clamps/packs.
module acc_requant #(
  parameter int SAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_intr,
  input  logic [30:0]      in_fpr,
  input  logic [4:0]       in_shift,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_value,
  output logic             out_last,
  input  logic             sat_clr,
  output logic [SAT_W-1:0] sat_cnt
);

  typedef enum logic {PK_EMPTY = 1'b0, PK_HALF = 1'b1} pk_state_t;

  localparam logic [SAT_W-1:0] SAT_MAX = {SAT_W{1'b1}};
  localparam logic [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

  // Returns {clamped, byte}: ReLU below zero, clamp above 255.
  function automatic logic [8:0] int_requant(input logic signed [25:0] sum, input logic [4:0] shift);
    logic signed [25:0] r;
    r = sum >>> shift;
    if (r < 26'sd0) begin
      int_requant = 9'h000;
    end else if (r > 26'sd255) begin
      int_requant = {1'b1, 8'hFF};
    end else begin
      int_requant = {1'b0, r[7:0]};
    end
  endfunction

  // Returns {saturated, word}; mantissa rounds half up and may carry into the exponent.
  function automatic logic [16:0] fp_requant(input logic [4:0] e, input logic [25:0] m);
    logic [12:0] man;
    logic [5:0]  e_inc;
    man   = {1'b0, m[23:12]} + {12'h000, m[11]};
    e_inc = {1'b0, e} + 6'd1;
    if (m[25] || (m == 26'd0)) begin
      fp_requant = 17'h00000;
    end else if (e > 5'd15) begin
      fp_requant = {1'b1, 16'hFFFF};
    end else if (man[12]) begin
      if (e_inc > 6'd15) begin
        fp_requant = {1'b1, 16'hFFFF};
      end else begin
        fp_requant = {1'b0, e_inc[3:0], 12'h000};
      end
    end else begin
      fp_requant = {1'b0, e[3:0], man[11:0]};
    end
  endfunction

  logic               s1_valid_r, s1_fp_r, s1_last_r;
  logic signed [25:0] s1_sum_r;
  logic [4:0]         s1_shift_r, s1_e_r;
  logic [25:0]        s1_m_r;
  pk_state_t          pk_state_r, pk_next_s;
  logic [7:0]         lo_r, lo_next_s;
  logic               out_valid_r, out_last_r;
  logic [15:0]        out_value_r;
  logic [SAT_W-1:0]   sat_cnt_r;

  logic        s1_adv_s, load_s, word_last_s, sat_inc_s, out_free_s, accept_s;
  logic [15:0] word_s;
  logic [8:0]  int_res_s;
  logic [16:0] fp_res_s;
  logic [25:0] round_s, sum_s;

  assign out_free_s = !out_valid_r || out_ready;
  assign in_ready   = !s1_valid_r || s1_adv_s;
  assign accept_s   = in_valid && in_ready;
  assign round_s    = (in_shift == 5'd0) ? 26'd0 : (26'd1 << (in_shift - 5'd1));
  assign sum_s      = {{2{in_intr[23]}}, in_intr} + round_s;
  assign int_res_s  = int_requant(s1_sum_r, s1_shift_r);
  assign fp_res_s   = fp_requant(s1_e_r, s1_m_r);

  assign out_valid = out_valid_r;
  assign out_value = out_value_r;
  assign out_last  = out_last_r;
  assign sat_cnt   = sat_cnt_r;

  // Packer next-state and S2 load decision; an fp beat behind a half word waits one cycle.
  always_comb begin
    s1_adv_s    = 1'b0;
    load_s      = 1'b0;
    word_s      = 16'h0000;
    word_last_s = 1'b0;
    pk_next_s   = pk_state_r;
    lo_next_s   = lo_r;
    sat_inc_s   = 1'b0;
    if (s1_valid_r) begin
      case ({s1_fp_r, pk_state_r == PK_HALF})
        2'b00: begin
          if (!s1_last_r) begin
            s1_adv_s  = 1'b1;
            pk_next_s = PK_HALF;
            lo_next_s = int_res_s[7:0];
            sat_inc_s = int_res_s[8];
          end else if (out_free_s) begin
            s1_adv_s    = 1'b1;
            load_s      = 1'b1;
            word_s      = {8'h00, int_res_s[7:0]};
            word_last_s = 1'b1;
            sat_inc_s   = int_res_s[8];
          end else begin
            s1_adv_s = 1'b0;
          end
        end
        2'b01: begin
          if (out_free_s) begin
            s1_adv_s    = 1'b1;
            load_s      = 1'b1;
            word_s      = {int_res_s[7:0], lo_r};
            word_last_s = s1_last_r;
            pk_next_s   = PK_EMPTY;
            sat_inc_s   = int_res_s[8];
          end else begin
            s1_adv_s = 1'b0;
          end
        end
        2'b10: begin
          if (out_free_s) begin
            s1_adv_s    = 1'b1;
            load_s      = 1'b1;
            word_s      = fp_res_s[15:0];
            word_last_s = s1_last_r;
            sat_inc_s   = fp_res_s[16];
          end else begin
            s1_adv_s = 1'b0;
          end
        end
        2'b11: begin
          if (out_free_s) begin
            load_s    = 1'b1;
            word_s    = {8'h00, lo_r};
            pk_next_s = PK_EMPTY;
          end else begin
            load_s = 1'b0;
          end
        end
        default: begin
          s1_adv_s = 1'b0;
        end
      endcase
    end else begin
      s1_adv_s = 1'b0;
    end
  end

  // S1: capture the accepted beat and pre-add the rounding constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_fp_r    <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sum_r   <= 26'sd0;
      s1_shift_r <= 5'd0;
      s1_e_r     <= 5'd0;
      s1_m_r     <= 26'd0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_fp_r    <= (mode == 2'b00);
      s1_last_r  <= in_last;
      s1_sum_r   <= sum_s;
      s1_shift_r <= in_shift;
      s1_e_r     <= in_fpr[30:26];
      s1_m_r     <= in_fpr[25:0];
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Packer state and the held low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_state_r <= PK_EMPTY;
      lo_r       <= 8'h00;
    end else begin
      pk_state_r <= pk_next_s;
      lo_r       <= lo_next_s;
    end
  end

  // S2 output register; the word holds until the downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_value_r <= 16'h0000;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_value_r <= word_s;
      out_last_r  <= word_last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturation event counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_r <= {SAT_W{1'b0}};
    end else if (sat_clr) begin
      sat_cnt_r <= {SAT_W{1'b0}};
    end else if (sat_inc_s && (sat_cnt_r != SAT_MAX)) begin
      sat_cnt_r <= sat_cnt_r + SAT_ONE;
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Self-checking bench for acc_requant: directed scenarios plus a randomized stream,
// compared against an arithmetic reference model with a word scoreboard.
module tb_acc_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid, in_ready;
  logic [23:0] in_intr;
  logic [30:0] in_fpr;
  logic [4:0]  in_shift;
  logic        in_last;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_value;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  bit          pend_v = 1'b0;
  logic [7:0]  pend_b = 8'h00;
  int          exp_sat = 0;
  int          bp_mode = 0;

  acc_requant #(.SAT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_intr(in_intr), .in_fpr(in_fpr), .in_shift(in_shift), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_last(out_last),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Downstream readiness: 0 always ready, 1 random, otherwise stalled.
  initial forever begin
    @(negedge clk);
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Collect every word the downstream actually takes.
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) obs_q.push_back({out_last, out_value});
  end

  // Reference: round-to-nearest division by 2^sh, floor semantics, then ReLU/clamp.
  function automatic logic [8:0] ref_int(input logic [23:0] intr, input int sh);
    longint v, d, r;
    logic [7:0] b;
    v = longint'($signed(intr));
    d = longint'(1) << sh;
    if (sh > 0) v = v + d / 2;
    if (v >= 0) r = v / d;
    else r = -((-v + d - 1) / d);
    if (r < 0) return 9'h000;
    if (r > 255) return {1'b1, 8'hFF};
    b = 8'(r);
    return {1'b0, b};
  endfunction

  // Reference: fraction below the leading one scaled to 12 bits, rounded half up.
  function automatic logic [16:0] ref_fp(input logic [4:0] e, input logic [25:0] m);
    longint mi;
    int ee, man;
    logic [3:0] e4;
    logic [11:0] m12;
    mi = longint'($signed(m));
    if (mi <= 0) return 17'h00000;
    ee = int'(e);
    if (ee > 15) return {1'b1, 16'hFFFF};
    man = int'(((mi % (longint'(1) << 24)) + 2048) / 4096);
    if (man == 4096) begin
      man = 0;
      ee = ee + 1;
    end
    if (ee > 15) return {1'b1, 16'hFFFF};
    e4 = 4'(ee);
    m12 = 12'(man);
    return {1'b0, e4, m12};
  endfunction

  function automatic void model_accept(input logic [1:0] md, input logic [23:0] intr,
                                       input logic [30:0] fpr, input logic [4:0] sh, input logic last);
    logic [16:0] f;
    logic [8:0] b;
    if (md == 2'b00) begin
      f = ref_fp(fpr[30:26], fpr[25:0]);
      if (pend_v) begin
        exp_q.push_back({1'b0, 8'h00, pend_b});
        pend_v = 1'b0;
      end
      exp_q.push_back({last, f[15:0]});
      if (f[16]) exp_sat++;
    end else begin
      b = ref_int(intr, int'(sh));
      if (b[8]) exp_sat++;
      if (pend_v) begin
        exp_q.push_back({last, b[7:0], pend_b});
        pend_v = 1'b0;
      end else if (last) begin
        exp_q.push_back({1'b1, 8'h00, b[7:0]});
      end else begin
        pend_b = b[7:0];
        pend_v = 1'b1;
      end
    end
  endfunction

  task automatic drive_beat(input logic [1:0] md, input logic [23:0] intr, input logic [30:0] fpr,
                            input logic [4:0] sh, input logic last);
    @(negedge clk);
    in_valid = 1'b1; mode = md; in_intr = intr; in_fpr = fpr; in_shift = sh; in_last = last;
    for (int k = 0; k < 200; k++) begin
      #4;
      if (in_ready) begin
        model_accept(md, intr, fpr, sh, last);
        return;
      end
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL drive_beat in_ready stayed 0 for 200 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (i >= 4 && obs_q.size() >= exp_q.size()) break;
    end
  endtask

  task automatic test_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_value !== 16'h0000) begin fails++; $display("FAIL reset_out_value got %h want 0000", out_value); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
    tests++; if (sat_cnt !== 16'h0000) begin fails++; $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_int_pair();
    logic [16:0] e, o;
    drive_beat(2'b01, 24'h000128, 31'h0, 5'd4, 1'b0);
    drive_beat(2'b01, 24'h001000, 31'h0, 5'd4, 1'b0);
    @(negedge clk); in_valid = 1'b0; #4;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pair_latency_t1 out_valid got %b want 0", out_valid); end
    @(negedge clk); #4;
    tests++; if ({out_valid, out_last, out_value} !== {1'b1, 1'b0, 16'hFF13}) begin
      fails++; $display("FAIL pair_latency_t2 got v=%b l=%b %h want v=1 l=0 ff13", out_valid, out_last, out_value);
    end
    tests++; if (sat_cnt !== 16'd1) begin fails++; $display("FAIL pair_sat got %0d want 1", sat_cnt); end
    wait_drain();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL pair_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL pair_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fp();
    logic [16:0] e, o;
    drive_beat(2'b00, 24'h0, {5'd7, 26'h1000800}, 5'd0, 1'b0);
    drive_beat(2'b00, 24'h0, {5'd7, 26'h1FFF800}, 5'd0, 1'b0);
    drive_beat(2'b00, 24'h0, {5'd15, 26'h1FFF800}, 5'd0, 1'b0);
    drive_beat(2'b00, 24'h0, {5'd7, 26'h2000000}, 5'd0, 1'b1);
    wait_drain();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL fp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL fp_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL fp_sat got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_last_flush();
    logic [16:0] e, o;
    drive_beat(2'b10, 24'd10, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b11, 24'd20, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b01, 24'd30, 31'h0, 5'd0, 1'b1);
    wait_drain();
    tests++; if (obs_q.size() != 2) begin fails++; $display("FAIL flush_count got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL flush_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_int_fp_mix();
    logic [16:0] e, o;
    drive_beat(2'b01, 24'h000005, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b00, 24'h0, {5'd3, 26'h1000000}, 5'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0; #4;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mix_in_ready_stall got %b want 0", in_ready); end
    @(negedge clk); #4;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mix_in_ready_resume got %b want 1", in_ready); end
    wait_drain();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL mix_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL mix_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [16:0] e, o, prev_val;
    bit prev_stall, saw_low;
    prev_stall = 1'b0; saw_low = 1'b0; prev_val = 17'h0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_beat(2'b01, 24'(i * 7 + 1), 31'h0, 5'd0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        bp_mode = 2;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk); #4;
          if (in_ready === 1'b0) saw_low = 1'b1;
          if (prev_stall) begin
            tests++;
            if ({out_last, out_value} !== prev_val) begin
              fails++; $display("FAIL bp_hold got %h want %h", {out_last, out_value}, prev_val);
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_val = {out_last, out_value};
        end
        bp_mode = 0;
      end
    join
    tests++; if (!saw_low) begin fails++; $display("FAIL bp_in_ready got 1 throughout stall want 0"); end
    wait_drain();
    tests++; if (obs_q.size() != 4) begin fails++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL bp_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [16:0] e, o;
    logic [1:0] md;
    logic [23:0] iv;
    logic [25:0] m;
    bp_mode = 1;
    for (int i = 0; i < 80; i++) begin
      md = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      iv = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 700)) - 24'd100 : 24'($urandom);
      m  = ($urandom_range(0, 3) == 0) ? {2'b10, 24'($urandom)} : {2'b01, 24'($urandom)};
      if ($urandom_range(0, 4) == 0) m[23:0] = 24'hFFF800 | 24'($urandom_range(0, 2047));
      drive_beat(md, iv, {5'($urandom_range(0, 17)), m}, 5'($urandom_range(0, 23)),
                 (i == 79) || ($urandom_range(0, 5) == 0));
    end
    wait_drain();
    bp_mode = 0;
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL rand_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL rand_sat got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_sat_clr();
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); #2;
    tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL satclr_clear got %0d want 0", sat_cnt); end
    drive_beat(2'b01, 24'h001000, 31'h0, 5'd0, 1'b1);
    wait_drain();
    exp_sat = 0;
    tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL satclr_wins got %0d want 0", sat_cnt); end
    tests++; if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 16'h00FF}) begin
      fails++; $display("FAIL satclr_word got %0d words want 1 word 100ff", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
    sat_clr = 1'b0;
    drive_beat(2'b01, 24'hFFFF00, 31'h0, 5'd0, 1'b1);
    wait_drain();
    exp_q.delete(); obs_q.delete();
    tests++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("FAIL satclr_relu got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_reset_midop();
    logic [16:0] e, o;
    bp_mode = 2;
    repeat (2) @(negedge clk);
    drive_beat(2'b01, 24'h001000, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b01, 24'd2, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b01, 24'd7, 31'h0, 5'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL midrst_sat got %0d want 0", sat_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); pend_v = 1'b0; exp_sat = 0;
    bp_mode = 0;
    repeat (2) @(negedge clk);
    drive_beat(2'b01, 24'd3, 31'h0, 5'd0, 1'b0);
    drive_beat(2'b01, 24'd4, 31'h0, 5'd0, 1'b0);
    wait_drain();
    tests++; if (obs_q.size() != 1) begin fails++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL midrst_word got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; in_intr = 24'h0; in_fpr = 31'h0;
    in_shift = 5'd0; in_last = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    test_reset();
    test_int_pair();
    test_fp();
    test_last_flush();
    test_int_fp_mix();
    test_backpressure();
    test_random();
    test_sat_clr();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
